// File: rtl/async_fifo_wptr_full_if.sv
// Write-side bus of the async FIFO pointer stage: producer request,
// read-domain Gray pointer in, memory address / flags / count out.
interface async_fifo_wptr_full_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W:0]   rd_gptr;
    logic [ADDR_W-1:0] b_wrptr;
    logic [ADDR_W:0]   g_wrptr;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wr_count;
    logic              overflow;

    // Producer / environment side.
    modport master (
        output wr_en,
        output rd_gptr,
        input  b_wrptr,
        input  g_wrptr,
        input  full,
        input  almost_full,
        input  wr_count,
        input  overflow
    );

    // Pointer-stage side.
    modport slave (
        input  wr_en,
        input  rd_gptr,
        output b_wrptr,
        output g_wrptr,
        output full,
        output almost_full,
        output wr_count,
        output overflow
    );
endinterface

// File: rtl/async_fifo_wptr_full.sv
// Write-domain control of the async FIFO: owns the binary/Gray write
// pointer, synchronises the read Gray pointer and derives full,
// almost_full, occupancy and a sticky overflow flag.
module async_fifo_wptr_full #(
    parameter int ADDR_W   = 4,
    parameter int AFULL_TH = 12
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    async_fifo_wptr_full_if.slave bus
);

    localparam logic [ADDR_W:0] AFULL_V = AFULL_TH[ADDR_W:0];

    logic [ADDR_W:0] r_wbin;
    logic [ADDR_W:0] r_gptr;
    logic [ADDR_W:0] r_rq1;
    logic [ADDR_W:0] r_rq2;
    logic [ADDR_W:0] r_count;
    logic            r_full;
    logic            r_afull;
    logic            r_ovf;

    logic            w_push;
    logic [ADDR_W:0] w_wbin_next;
    logic [ADDR_W:0] w_gray_next;
    logic [ADDR_W:0] w_rbin;
    logic [ADDR_W:0] w_count_next;
    logic            w_full_next;

    // Next pointer, synchronised read position and the flags derived from them.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_rbin       = r_rq2;
        w_push       = bus.wr_en & ~r_full;
        w_wbin_next  = r_wbin + {{ADDR_W{1'b0}}, w_push};
        w_gray_next  = (w_wbin_next >> 1) ^ w_wbin_next;
        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
        for (int i = 1; i <= ADDR_W; i++) begin
            w_rbin = w_rbin ^ (r_rq2 >> i);
        end
        w_count_next = w_wbin_next - w_rbin;
        // Full when the write pointer is one lap ahead: top two Gray bits inverted.
        w_full_next  = (w_gray_next == {~r_rq2[ADDR_W:ADDR_W-1], r_rq2[ADDR_W-2:0]});
    end

    // Two-flop synchroniser for the read Gray pointer; only r_rq2 is used.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_rq1 <= '0;
            r_rq2 <= '0;
        end else begin
            // NOTE: non-blocking so r_rq2 takes the previous r_rq1, giving two stages.
            r_rq1 <= bus.rd_gptr;
            r_rq2 <= r_rq1;
        end
    end

    // Write pointer, registered flags and occupancy.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_wbin  <= '0;
            r_gptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_gptr  <= w_gray_next;
            r_count <= w_count_next;
            r_full  <= w_full_next;
            r_afull <= (w_count_next >= AFULL_V);
            r_ovf   <= r_ovf | (bus.wr_en & r_full);
        end
    end

    assign bus.b_wrptr     = r_wbin[ADDR_W-1:0];
    assign bus.g_wrptr     = r_gptr;
    assign bus.full        = r_full;
    assign bus.almost_full = r_afull;
    assign bus.wr_count    = r_count;
    assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Directed bench for async_fifo_wptr_full with default parameters
// (16-entry FIFO, almost_full threshold 12).
module tb_async_fifo_wptr_full;

    logic wr_clk = 1'b0;
    logic wr_rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    async_fifo_wptr_full_if #(.ADDR_W(4)) bus ();

    async_fifo_wptr_full #(
        .ADDR_W   (4),
        .AFULL_TH (12)
    ) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .bus    (bus.slave)
    );

    always #5 wr_clk = ~wr_clk;

    function automatic logic [4:0] bin2gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // One rising edge; return on the following falling edge for sampling/driving.
    task automatic tick();
        @(posedge wr_clk);
        @(negedge wr_clk);
    endtask

    task automatic do_reset();
        bus.wr_en   = 1'b0;
        bus.rd_gptr = '0;
        wr_rst      = 1'b1;
        tick();
        wr_rst      = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.wr_en   = 1'b0;
        bus.rd_gptr = '0;
        #1 wr_rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.b_wrptr, bus.g_wrptr, bus.full, bus.almost_full, bus.wr_count, bus.overflow} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_async: outputs=%h required 0 (no clock edge yet)",
                     {bus.b_wrptr, bus.g_wrptr, bus.full, bus.almost_full, bus.wr_count, bus.overflow});
        end
        @(negedge wr_clk);
        wr_rst = 1'b0;
        tick();
        n_checks++;
        if (bus.full !== 1'b0 || bus.wr_count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_release: full=%b wr_count=%0d required 0/0", bus.full, bus.wr_count);
        end
    endtask

    task automatic test_fill();
        bus.rd_gptr = '0;
        bus.wr_en   = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            n_checks++;
            if (bus.b_wrptr !== 4'(k - 1)) begin
                n_fail++;
                $display("FAIL fill_addr[%0d]: b_wrptr=%0d required %0d", k, bus.b_wrptr, k - 1);
            end
            tick();
            n_checks++;
            if (bus.almost_full !== (k >= 12)) begin
                n_fail++;
                $display("FAIL fill_afull[%0d]: almost_full=%b required %b", k, bus.almost_full, k >= 12);
            end
            n_checks++;
            if (bus.full !== (k == 16)) begin
                n_fail++;
                $display("FAIL fill_full[%0d]: full=%b required %b", k, bus.full, k == 16);
            end
        end
        n_checks++;
        if (bus.g_wrptr !== 5'b11000 || bus.wr_count !== 5'd16 || bus.b_wrptr !== 4'd0) begin
            n_fail++;
            $display("FAIL fill_end: g_wrptr=%b wr_count=%0d b_wrptr=%0d required 11000/16/0",
                     bus.g_wrptr, bus.wr_count, bus.b_wrptr);
        end
    endtask

    task automatic test_overflow();
        bus.wr_en = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.g_wrptr !== 5'b11000 || bus.b_wrptr !== 4'd0 || bus.wr_count !== 5'd16 || bus.full !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_hold: g_wrptr=%b b_wrptr=%0d wr_count=%0d full=%b required 11000/0/16/1",
                     bus.g_wrptr, bus.b_wrptr, bus.wr_count, bus.full);
        end
        n_checks++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: overflow=%b required 1", bus.overflow);
        end
        bus.wr_en = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: overflow=%b required 1", bus.overflow);
        end
    endtask

    task automatic test_release_latency();
        bus.rd_gptr = 5'b00001;
        tick();
        tick();
        n_checks++;
        if (bus.full !== 1'b1) begin
            n_fail++;
            $display("FAIL release_early: full=%b required 1 after 2 edges", bus.full);
        end
        tick();
        n_checks++;
        if (bus.full !== 1'b0 || bus.wr_count !== 5'd15 || bus.almost_full !== 1'b1) begin
            n_fail++;
            $display("FAIL release_edge3: full=%b wr_count=%0d almost_full=%b required 0/15/1",
                     bus.full, bus.wr_count, bus.almost_full);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] wb;
        logic [4:0] prev_g;
        bit         wrapped;
        do_reset();
        bus.wr_en = 1'b1;
        repeat (4) tick();
        bus.wr_en = 1'b0;
        wb      = 5'd4;
        prev_g  = bin2gray(wb);
        wrapped = 1'b0;
        for (int p = 0; p < 40; p++) begin
            bus.wr_en = 1'b1;
            tick();
            bus.wr_en   = 1'b0;
            wb          = wb + 5'd1;
            bus.rd_gptr = bin2gray(wb - 5'd4);
            n_checks++;
            if ($countones(bus.g_wrptr ^ prev_g) != 1 || bus.g_wrptr !== bin2gray(wb)) begin
                n_fail++;
                $display("FAIL wrap_gray[%0d]: g_wrptr=%b prev=%b required %b (one-bit step)",
                         p, bus.g_wrptr, prev_g, bin2gray(wb));
            end
            prev_g = bus.g_wrptr;
            if (wb == 5'd0) wrapped = 1'b1;
            repeat (3) tick();
            n_checks++;
            if (bus.wr_count !== 5'd4 || bus.full !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_count[%0d]: wr_count=%0d full=%b required 4/0",
                         p, bus.wr_count, bus.full);
            end
        end
        n_checks++;
        if (!wrapped || bus.b_wrptr !== 4'(wb) || bus.g_wrptr !== bin2gray(5'd12)) begin
            n_fail++;
            $display("FAIL wrap_end: wrapped=%0d b_wrptr=%0d g_wrptr=%b required 1/12/%b",
                     wrapped, bus.b_wrptr, bus.g_wrptr, bin2gray(5'd12));
        end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        bus.wr_en = 1'b1;
        repeat (7) tick();
        bus.wr_en = 1'b0;
        n_checks++;
        if (bus.b_wrptr !== 4'd7 || bus.wr_count !== 5'd7) begin
            n_fail++;
            $display("FAIL midrst_pre: b_wrptr=%0d wr_count=%0d required 7/7", bus.b_wrptr, bus.wr_count);
        end
        wr_rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.b_wrptr, bus.g_wrptr, bus.full, bus.almost_full, bus.wr_count, bus.overflow} !== 17'd0) begin
            n_fail++;
            $display("FAIL midrst_async: outputs=%h required 0",
                     {bus.b_wrptr, bus.g_wrptr, bus.full, bus.almost_full, bus.wr_count, bus.overflow});
        end
        wr_rst    = 1'b0;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        n_checks++;
        if (bus.b_wrptr !== 4'd1 || bus.wr_count !== 5'd1 || bus.g_wrptr !== 5'b00001) begin
            n_fail++;
            $display("FAIL midrst_next: b_wrptr=%0d wr_count=%0d g_wrptr=%b required 1/1/00001",
                     bus.b_wrptr, bus.wr_count, bus.g_wrptr);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release_latency();
        test_wrap();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
